display_buffer_arbiter: RTL and testbench

Owns the 12-line x 9-character text buffer that drives the packed `words` bus consumed by the VGA text renderer. Two requesters share write access to the buffer: A (keypad/item entry) and B (price/total updater). Each requester writes single character cells. A clear sequencer blanks the whole buffer on request. All buffer updates are committed only during vertical blanking, so a frame never shows a half-updated buffer.

---
 rtl/display_pkg.sv | 43 ++++
 rtl/write_slot.sv | 63 ++++++
 rtl/display_buffer_arbiter.sv | 179 +++++++++++++++++
 tb/tb_display_buffer_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the text display buffer.
//   - Buffer geometry: N_LINES x N_CHARS cells of CHAR_W bits, packed into a
//     WORDS_W-bit bus with line 0 / column 0 in the most significant bits.
//   - BLANK_CODE: code written by reset and by the clear sequencer.
//   - VBLANK_START: first vertical line of the commit window.
//   - cell_msb(): maps (line, col) to the MSB bit offset of that cell.
//   - clr_state_e: states of the clear sequencer.
//   - cell_wr_t: one pending single-cell write.
// -----------------------------------------------------------------------------
package display_pkg;

  localparam int N_LINES = 12;
  localparam int N_CHARS = 9;
  localparam int CHAR_W  = 7;
  localparam int IDX_W   = 4;
  localparam int LINE_W  = N_CHARS * CHAR_W;   // 63
  localparam int WORDS_W = N_LINES * LINE_W;   // 756

  localparam logic [CHAR_W-1:0] BLANK_CODE   = 7'h20;
  localparam logic [9:0]        VBLANK_START = 10'd600;

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    CLEAR
  } clr_state_e;

  typedef struct packed {
    logic [IDX_W-1:0]  line;
    logic [IDX_W-1:0]  col;
    logic [CHAR_W-1:0] code;
  } cell_wr_t;

  // MSB position of cell (line, col) on the packed bus:
  // 755 - 63*line - 7*col. Callers guarantee line/col are in range.
  function automatic int cell_msb(input logic [IDX_W-1:0] line,
                                  input logic [IDX_W-1:0] col);
    return WORDS_W - 1 - LINE_W * int'(line) - CHAR_W * int'(col);
  endfunction

endpackage

// File: rtl/write_slot.sv
// -----------------------------------------------------------------------------
// write_slot
// One-entry valid/ready holding register for a single requester.
// An accepted in-range write is parked until the arbiter pops it; an accepted
// out-of-range write is dropped and reported with a one-cycle oob_err pulse.
//
// Ports:
//   CLK, RST     clock (rising edge), asynchronous active-high reset
//   req          write valid from the requester
//   line, col    target cell (unsigned, 4 bits each)
//   code         character code
//   enable       new writes allowed (clear sequencer idle)
//   pop          arbiter commits the held entry this cycle
//   gnt          ready to the requester (slot empty and enabled)
//   full         slot holds a pending write
//   entry        the pending write
//   oob_err      pulses the cycle after an out-of-range write is accepted
// -----------------------------------------------------------------------------
module write_slot
  import display_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              req,
  input  logic [IDX_W-1:0]  line,
  input  logic [IDX_W-1:0]  col,
  input  logic [CHAR_W-1:0] code,
  input  logic              enable,
  input  logic              pop,
  output logic              gnt,
  output logic              full,
  output cell_wr_t          entry,
  output logic              oob_err
);

  logic accept;
  logic in_range;

  // gnt depends only on registered state, so a slot that commits this cycle
  // cannot also accept this cycle.
  assign gnt      = !full && enable;
  assign accept   = req && gnt;
  assign in_range = (line < IDX_W'(N_LINES)) && (col < IDX_W'(N_CHARS));

  // NOTE: every register in a clocked block uses <= so all flops sample the
  // pre-edge values; a blocking = here would create order-dependent races.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      full    <= 1'b0;
      entry   <= '0;
      oob_err <= 1'b0;
    end else begin
      oob_err <= accept && !in_range;
      if (accept && in_range) begin
        full  <= 1'b1;
        entry <= '{line: line, col: col, code: code};
      end else if (pop) begin
        full  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/display_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// display_buffer_arbiter
// Owns the 12 x 9 character buffer feeding the VGA text renderer. Two
// requesters (A: keypad/item entry, B: price/total updater) each park single
// cell writes in their own write_slot; the arbiter commits at most one slot per
// cycle, round-robin, and only while ve_counter is inside vertical blanking so
// a frame never shows a half-updated buffer. A clear sequencer drains pending
// writes, then blanks one line per in-window cycle.
//
// Ports:
//   CLK, RST                 clock (rising edge), asynchronous active-high reset
//   ve_counter               vertical line count; commit window is >= 600
//   req_x/line_x/col_x/char_x  write request from requester x (a or b)
//   gnt_x                    ready to requester x
//   clr_req                  clear-screen request, sampled only when idle
//   clr_busy                 high from clear acceptance until line 11 is blank
//   oob_err                  one-cycle pulse after an out-of-range write
//   words                    packed buffer, line 0 / column 0 in the MSBs
// -----------------------------------------------------------------------------
module display_buffer_arbiter
  import display_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [9:0]         ve_counter,
  input  logic               req_a,
  input  logic [IDX_W-1:0]   line_a,
  input  logic [IDX_W-1:0]   col_a,
  input  logic [CHAR_W-1:0]  char_a,
  output logic               gnt_a,
  input  logic               req_b,
  input  logic [IDX_W-1:0]   line_b,
  input  logic [IDX_W-1:0]   col_b,
  input  logic [CHAR_W-1:0]  char_b,
  output logic               gnt_b,
  input  logic               clr_req,
  output logic               clr_busy,
  output logic               oob_err,
  output logic [WORDS_W-1:0] words
);

  clr_state_e       state, state_next;
  logic [IDX_W-1:0] clr_line, clr_line_next;
  logic             clr_wipe;
  logic             in_window;
  logic             slot_en;
  logic             rr_b;         // 1: B wins when both slots are full
  logic             full_a, full_b;
  logic             pop_a, pop_b;
  logic             oob_a, oob_b;
  cell_wr_t         entry_a, entry_b, win;
  logic [WORDS_W-1:0] words_q;

  assign in_window = (ve_counter >= VBLANK_START);
  assign slot_en   = (state == IDLE);
  assign clr_busy  = (state != IDLE);
  assign oob_err   = oob_a || oob_b;
  assign words     = words_q;

  write_slot u_slot_a (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req_a),
    .line    (line_a),
    .col     (col_a),
    .code    (char_a),
    .enable  (slot_en),
    .pop     (pop_a),
    .gnt     (gnt_a),
    .full    (full_a),
    .entry   (entry_a),
    .oob_err (oob_a)
  );

  write_slot u_slot_b (
    .CLK     (CLK),
    .RST     (RST),
    .req     (req_b),
    .line    (line_b),
    .col     (col_b),
    .code    (char_b),
    .enable  (slot_en),
    .pop     (pop_b),
    .gnt     (gnt_b),
    .full    (full_b),
    .entry   (entry_b),
    .oob_err (oob_b)
  );

  // Commit selection. Slots can only be full in IDLE or DRAIN; CLEAR is
  // excluded explicitly so a line wipe and a cell write never collide.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    pop_a = 1'b0;
    pop_b = 1'b0;
    if (in_window && (state != CLEAR)) begin
      if (full_a && (!full_b || !rr_b)) begin
        pop_a = 1'b1;
      end else if (full_b) begin
        pop_b = 1'b1;
      end
    end
  end

  assign win = pop_b ? entry_b : entry_a;

  // Pointer always moves to the requester that did not just commit.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_b <= 1'b0;
    end else if (pop_a) begin
      rr_b <= 1'b1;
    end else if (pop_b) begin
      rr_b <= 1'b0;
    end
  end

  // Clear sequencer: state register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= IDLE;
      clr_line <= '0;
    end else begin
      state    <= state_next;
      clr_line <= clr_line_next;
    end
  end

  // Clear sequencer: next state. DRAIN waits for both slots to empty inside a
  // window; CLEAR wipes one line per in-window cycle and holds its index while
  // the window is closed.
  always_comb begin
    state_next    = state;
    clr_line_next = clr_line;
    clr_wipe      = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!full_a && !full_b && in_window) begin
          state_next    = CLEAR;
          clr_line_next = '0;
        end
      end
      CLEAR: begin
        if (in_window) begin
          clr_wipe = 1'b1;
          if (clr_line == IDX_W'(N_LINES - 1)) begin
            state_next = IDLE;
          end else begin
            clr_line_next = clr_line + 1'b1;
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Character buffer.
  // NOTE: the buffer is flop storage rather than a RAM macro, so it takes the
  // asynchronous reset and comes up fully blank.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      words_q <= {(N_LINES * N_CHARS){BLANK_CODE}};
    end else if (clr_wipe) begin
      words_q[cell_msb(clr_line, '0) -: LINE_W] <= {N_CHARS{BLANK_CODE}};
    end else if (pop_a || pop_b) begin
      // Slots only ever hold in-range cells, so the offset is always valid.
      words_q[cell_msb(win.line, win.col) -: CHAR_W] <= win.code;
    end
  end

endmodule

// File: tb/tb_display_buffer_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_buffer_arbiter
// Directed bench for display_buffer_arbiter: a table of single-cycle vectors
// for handshake/commit/oob behaviour, then hand-written sequences for the
// clear sequencer (drain, window straddle) and asynchronous reset mid-clear.
// -----------------------------------------------------------------------------
module tb_display_buffer_arbiter;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [9:0]   ve_counter = 10'd100;
  logic         req_a = 1'b0, req_b = 1'b0;
  logic [3:0]   line_a = '0, col_a = '0, line_b = '0, col_b = '0;
  logic [6:0]   char_a = '0, char_b = '0;
  logic         clr_req = 1'b0;
  logic         gnt_a, gnt_b, clr_busy, oob_err;
  logic [755:0] words;

  int checks = 0;
  int errors = 0;

  // Independent view of the bus: line 0 / column 0 are the leftmost fields.
  typedef logic [0:11][0:8][6:0] grid_t;

  localparam logic [755:0] ALL_BLANK  = {108{7'h20}};
  localparam logic [62:0]  LINE_BLANK = {9{7'h20}};

  typedef struct {
    logic [9:0] ve;
    logic       ra;
    logic [3:0] la, ca;
    logic [6:0] da;
    logic       rb;
    logic [3:0] lb, cb;
    logic [6:0] db;
    logic       eg_a, eg_b, e_oob;
    int         cl, cc;
    logic [6:0] e_char;
  } vec_t;

  vec_t vecs[18];

  display_buffer_arbiter dut (
    .CLK        (CLK),
    .RST        (RST),
    .ve_counter (ve_counter),
    .req_a      (req_a),
    .line_a     (line_a),
    .col_a      (col_a),
    .char_a     (char_a),
    .gnt_a      (gnt_a),
    .req_b      (req_b),
    .line_b     (line_b),
    .col_b      (col_b),
    .char_b     (char_b),
    .gnt_b      (gnt_b),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .oob_err    (oob_err),
    .words      (words)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] cell_of(input int l, input int c);
    grid_t g;
    g = words;
    return g[l][c];
  endfunction

  function automatic logic [62:0] line_of(input int l);
    grid_t g;
    g = words;
    return g[l];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_words(input string name, input logic [755:0] exp);
    checks++;
    if (words !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, words, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Write one cell inside the window and let it commit.
  task automatic do_write(input bit is_b, input int l, input int c, input logic [6:0] ch);
    ve_counter = 10'd600;
    if (is_b) begin
      req_b = 1'b1; line_b = 4'(l); col_b = 4'(c); char_b = ch;
    end else begin
      req_a = 1'b1; line_a = 4'(l); col_a = 4'(c); char_a = ch;
    end
    step();
    req_a = 1'b0;
    req_b = 1'b0;
    step();
  endtask

  initial begin
    //          ve      ra  la  ca  da      rb  lb  cb  db      ga gb oob  cl cc  char
    vecs[0]  = '{10'd100, 1, 2, 3, 7'h41,  0, 0, 0, 7'h00,  0, 1, 0,   2, 3, 7'h20};
    vecs[1]  = '{10'd100, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  0, 1, 0,   2, 3, 7'h20};
    vecs[2]  = '{10'd600, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 1, 0,   2, 3, 7'h41};
    vecs[3]  = '{10'd600, 0, 0, 0, 7'h00,  1, 5, 8, 7'h55,  1, 0, 0,   5, 8, 7'h20};
    vecs[4]  = '{10'd600, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 1, 0,   5, 8, 7'h55};
    vecs[5]  = '{10'd100, 1, 0, 0, 7'h31,  1, 0, 0, 7'h32,  0, 0, 0,   0, 0, 7'h20};
    vecs[6]  = '{10'd600, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 0, 0,   0, 0, 7'h31};
    vecs[7]  = '{10'd600, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 1, 0,   0, 0, 7'h32};
    vecs[8]  = '{10'd600, 1, 1, 1, 7'h61,  1, 1, 1, 7'h62,  0, 0, 0,   1, 1, 7'h20};
    vecs[9]  = '{10'd600, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 0, 0,   1, 1, 7'h61};
    vecs[10] = '{10'd600, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 1, 0,   1, 1, 7'h62};
    vecs[11] = '{10'd100, 1, 12, 0, 7'h41, 0, 0, 0, 7'h00,  1, 1, 1,   0, 0, 7'h32};
    vecs[12] = '{10'd100, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 1, 0,   0, 0, 7'h32};
    vecs[13] = '{10'd100, 0, 0, 0, 7'h00,  1, 3, 9, 7'h44,  1, 1, 1,   3, 8, 7'h20};
    vecs[14] = '{10'd100, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 1, 0,   3, 8, 7'h20};
    vecs[15] = '{10'd100, 1, 11, 8, 7'h7f, 0, 0, 0, 7'h00,  0, 1, 0,  11, 8, 7'h20};
    vecs[16] = '{10'd599, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  0, 1, 0,  11, 8, 7'h20};
    vecs[17] = '{10'd600, 0, 0, 0, 7'h00,  0, 0, 0, 7'h00,  1, 1, 0,  11, 8, 7'h7f};

    // Reset and idle state.
    repeat (2) @(posedge CLK);
    #1 RST = 1'b0;
    step();
    check_words("reset_words", ALL_BLANK);
    check("reset_gnt_a", 64'(gnt_a), 64'd1);
    check("reset_gnt_b", 64'(gnt_b), 64'd1);
    check("reset_clr_busy", 64'(clr_busy), 64'd0);
    check("reset_oob", 64'(oob_err), 64'd0);

    // Table: handshake, window gating, round-robin, out-of-range, boundaries.
    for (int i = 0; i < 18; i++) begin
      ve_counter = vecs[i].ve;
      req_a = vecs[i].ra; line_a = vecs[i].la; col_a = vecs[i].ca; char_a = vecs[i].da;
      req_b = vecs[i].rb; line_b = vecs[i].lb; col_b = vecs[i].cb; char_b = vecs[i].db;
      step();
      req_a = 1'b0;
      req_b = 1'b0;
      check($sformatf("vec%0d_gnt_a", i), 64'(gnt_a), 64'(vecs[i].eg_a));
      check($sformatf("vec%0d_gnt_b", i), 64'(gnt_b), 64'(vecs[i].eg_b));
      check($sformatf("vec%0d_oob", i), 64'(oob_err), 64'(vecs[i].e_oob));
      check($sformatf("vec%0d_busy", i), 64'(clr_busy), 64'd0);
      check($sformatf("vec%0d_cell", i), 64'(cell_of(vecs[i].cl, vecs[i].cc)), 64'(vecs[i].e_char));
    end

    // Clear with B slot pending outside the window.
    ve_counter = 10'd100;
    req_b = 1'b1; line_b = 4'd4; col_b = 4'd4; char_b = 7'h42;
    step();
    req_b = 1'b0;
    check("clr1_b_full_gnt_b", 64'(gnt_b), 64'd0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    check("clr1_busy_set", 64'(clr_busy), 64'd1);
    check("clr1_gnt_a_low", 64'(gnt_a), 64'd0);
    check("clr1_gnt_b_low", 64'(gnt_b), 64'd0);
    step();
    check("clr1_no_commit_outside", 64'(cell_of(4, 4)), 64'h20);
    ve_counter = 10'd600;
    step();
    check("clr1_b_drained", 64'(cell_of(4, 4)), 64'h42);
    check("clr1_busy_drain", 64'(clr_busy), 64'd1);
    step();
    check("clr1_line0_not_yet", 64'(cell_of(0, 0)), 64'h32);
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("clr1_line%0d_blank", i), 64'(line_of(i)), 64'(LINE_BLANK));
      check($sformatf("clr1_busy_%0d", i), 64'(clr_busy), (i == 11) ? 64'd0 : 64'd1);
      if (i == 3) check("clr1_line4_pending", 64'(cell_of(4, 4)), 64'h42);
    end
    check_words("clr1_all_blank", ALL_BLANK);
    check("clr1_gnt_a_back", 64'(gnt_a), 64'd1);
    check("clr1_gnt_b_back", 64'(gnt_b), 64'd1);

    // Clear straddling the end of the window.
    do_write(1'b0, 0, 5, 7'h30);
    do_write(1'b0, 4, 0, 7'h4a);
    do_write(1'b1, 11, 2, 7'h4b);
    check("clr2_setup", 64'(cell_of(0, 5)), 64'h30);
    ve_counter = 10'd622;
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    repeat (4) step();
    ve_counter = 10'd100;
    repeat (2) step();
    check("clr2_line0_blank", 64'(cell_of(0, 5)), 64'h20);
    check("clr2_line3_blank", 64'(line_of(3)), 64'(LINE_BLANK));
    check("clr2_line4_old", 64'(cell_of(4, 0)), 64'h4a);
    check("clr2_line11_old", 64'(cell_of(11, 2)), 64'h4b);
    check("clr2_busy_held", 64'(clr_busy), 64'd1);
    check("clr2_gnt_a_low", 64'(gnt_a), 64'd0);
    ve_counter = 10'd600;
    repeat (7) step();
    check("clr2_line4_resumed", 64'(cell_of(4, 0)), 64'h20);
    check("clr2_line11_last", 64'(cell_of(11, 2)), 64'h4b);
    check("clr2_busy_before_last", 64'(clr_busy), 64'd1);
    step();
    check("clr2_busy_done", 64'(clr_busy), 64'd0);
    check_words("clr2_all_blank", ALL_BLANK);

    // Asynchronous reset in the middle of a clear.
    do_write(1'b0, 9, 1, 7'h5a);
    do_write(1'b1, 0, 2, 7'h5b);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    step();
    step();
    check("rst_pre_busy", 64'(clr_busy), 64'd1);
    check("rst_pre_line9", 64'(cell_of(9, 1)), 64'h5a);
    #1 RST = 1'b1;
    #1;
    check_words("rst_mid_clear_blank", ALL_BLANK);
    check("rst_mid_busy", 64'(clr_busy), 64'd0);
    check("rst_mid_gnt_a", 64'(gnt_a), 64'd1);
    check("rst_mid_gnt_b", 64'(gnt_b), 64'd1);
    #1 RST = 1'b0;
    do_write(1'b0, 6, 6, 7'h66);
    check("rst_after_write", 64'(cell_of(6, 6)), 64'h66);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
